stack_ctl: RTL and testbench



---
 rtl/forthsuper_pkg.sv | 44 ++++
 rtl/stack_ctl_if.sv | 31 +++
 rtl/stk_io.sv | 19 +
 rtl/stack3.sv | 48 ++++
 rtl/stack_ctl.sv | 161 ++++++++++++++++
 tb/tb_stack_ctl.sv | 284 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/forthsuper_pkg.sv
`default_nettype none
// =====================================================================
// forthsuper_pkg : shared enums and helpers for the Forth stack blocks
// rev 1.0
// =====================================================================
package forthsuper_pkg;

  typedef enum logic [1:0] {
    SOP_READ = 2'd0,
    SOP_PUSH = 2'd1,
    SOP_POP  = 2'd2
  } stack_ops;

  typedef enum logic [3:0] {
    CMD_NOP  = 4'd0,
    CMD_PUSH = 4'd1,
    CMD_DROP = 4'd2,
    CMD_DUP  = 4'd3,
    CMD_SWAP = 4'd4,
    CMD_OVER = 4'd5,
    CMD_NIP  = 4'd6,
    CMD_ROT  = 4'd7,
    CMD_REPL = 4'd8,
    CMD_BIN  = 4'd9
  } stk_cmd;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_ROTW = 2'd2
  } stk_state;

  // Minimum logical depth a command needs to be meaningful.
  function automatic logic [1:0] min_depth(input logic [3:0] c);
    case (c)
      CMD_DROP, CMD_DUP, CMD_REPL:          min_depth = 2'd1;
      CMD_SWAP, CMD_OVER, CMD_NIP, CMD_BIN: min_depth = 2'd2;
      CMD_ROT:                              min_depth = 2'd3;
      default:                              min_depth = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/stack_ctl_if.sv
`default_nettype none
// =====================================================================
// stack_ctl_if : command port and memory monitor of stack_ctl
// rev 1.0
// =====================================================================
interface stack_ctl_if #(
  parameter int DEPTH = 64,
  parameter int DSZ   = 32
) ();
  localparam int DW = $clog2(DEPTH) + 1;

  logic           req;
  logic [3:0]     cmd;
  logic [DSZ-1:0] din;
  logic           rdy;
  logic [DSZ-1:0] tos;
  logic [DSZ-1:0] nos;
  logic [DW-1:0]  depth;
  logic           ovf;
  logic           udf;
  logic [1:0]     mem_op;
  logic [DSZ-1:0] mem_vi;
  logic [DSZ-1:0] mem_vo;
  logic           mem_en;

  modport master (output req, cmd, din,
                  input  rdy, tos, nos, depth, ovf, udf, mem_op, mem_vi, mem_vo, mem_en);
  modport slave  (input  req, cmd, din,
                  output rdy, tos, nos, depth, ovf, udf, mem_op, mem_vi, mem_vo, mem_en);
endinterface
`default_nettype wire

// File: rtl/stk_io.sv
`default_nettype none
// =====================================================================
// stk_io : port between stack_ctl and the stack3 memory
// rev 1.0
// =====================================================================
interface stk_io
  import forthsuper_pkg::*;
#(
  parameter int DSZ = 32
) ();
  stack_ops       op;
  logic           en;
  logic [DSZ-1:0] vi;
  logic [DSZ-1:0] vo;

  modport ctl (output op, en, vi, input vo);
  modport mem (input op, en, vi, output vo);
endinterface
`default_nettype wire

// File: rtl/stack3.sv
`default_nettype none
// =====================================================================
// stack3 : single-port circular EBR stack, registered read on POP
// rev 1.0
// =====================================================================
module stack3
  import forthsuper_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int DSZ   = 32
) (
  input  logic clk,
  input  logic rst,
  stk_io.mem   io
);
  localparam int AW = $clog2(DEPTH);

  // DEPTH must be a power of two so the pointer wraps onto the ring.
  logic [DSZ-1:0] cells [DEPTH];
  logic [AW-1:0]  sp;
  logic [AW-1:0]  sp_dec;
  logic [DSZ-1:0] vo;

  assign sp_dec = sp - AW'(1);
  assign io.vo  = vo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= '0;
      vo <= '0;
    end else if (io.en) begin
      if (io.op == SOP_PUSH) begin
        sp <= sp + AW'(1);
      end else if (io.op == SOP_POP) begin
        sp <= sp_dec;
        vo <= cells[sp_dec];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (io.en && io.op == SOP_PUSH) begin
      cells[sp] <= io.vi;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stack_ctl.sv
`default_nettype none
// =====================================================================
// stack_ctl : Forth stack controller caching TOS/NOS over a stack3 EBR
// Optional macro STK_GUARD_EN: discard overflowing/underflowing commands
// rev 1.0
// =====================================================================
module stack_ctl
  import forthsuper_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int DSZ   = 32
) (
  input  logic       clk,
  input  logic       rst,
  stack_ctl_if.slave bus
);
  localparam int DW = $clog2(DEPTH) + 1;

  stk_state       state, state_nx;
  logic [DSZ-1:0] tos, nos, tmp;
  logic [DSZ-1:0] tos_nx, nos_nx, tmp_nx;
  logic [DW-1:0]  depth, depth_nx;
  logic           ovf, udf, ovf_nx, udf_nx;
  logic [3:0]     cmd;
  logic           accept, exec, grows, shrinks, rot;
  logic           over_hit, under_hit;
  stack_ops       mem_op;
  logic           mem_en;
  logic [DSZ-1:0] mem_vi;

  stk_io #(.DSZ(DSZ)) mio ();

  stack3 #(.DEPTH(DEPTH), .DSZ(DSZ)) u_stack3 (
    .clk (clk),
    .rst (rst),
    .io  (mio)
  );

  assign cmd    = bus.cmd;
  assign accept = bus.req && (state == ST_IDLE);

  always_comb begin
    grows   = 1'b0;
    shrinks = 1'b0;
    rot     = 1'b0;
    case (cmd)
      CMD_PUSH, CMD_DUP, CMD_OVER: grows   = 1'b1;
      CMD_DROP, CMD_NIP, CMD_BIN:  shrinks = 1'b1;
      CMD_ROT:                     rot     = 1'b1;
      default: ;
    endcase
  end

`ifdef STK_GUARD_EN
  assign over_hit  = grows && (depth == DW'(DEPTH));
  assign under_hit = depth < DW'(min_depth(cmd));
`else
  assign over_hit  = 1'b0;
  assign under_hit = 1'b0;
`endif

  assign exec = accept && !over_hit && !under_hit;

  always_comb begin
    state_nx = state;
    tos_nx   = tos;
    nos_nx   = nos;
    tmp_nx   = tmp;
    depth_nx = depth;
    ovf_nx   = ovf;
    udf_nx   = udf;
    mem_op   = SOP_READ;
    mem_en   = 1'b0;
    mem_vi   = nos;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          ovf_nx = ovf | over_hit;
          udf_nx = udf | under_hit;
        end
        if (exec) begin
          // NOS spills even when it holds no valid item, keeping memory == depth.
          if (grows) begin
            mem_op   = SOP_PUSH;
            mem_en   = 1'b1;
            depth_nx = depth + DW'(1);
          end
          if (shrinks || rot) begin
            mem_op = SOP_POP;
            mem_en = 1'b1;
          end
          if (shrinks) begin
            depth_nx = depth - DW'(1);
          end
          case (cmd)
            CMD_PUSH: begin nos_nx = tos; tos_nx = bus.din; end
            CMD_DROP: begin tos_nx = nos; state_nx = ST_FILL; end
            CMD_DUP:  nos_nx = tos;
            CMD_SWAP: begin tos_nx = nos; nos_nx = tos; end
            CMD_OVER: begin tos_nx = nos; nos_nx = tos; end
            CMD_NIP:  state_nx = ST_FILL;
            CMD_ROT:  begin tmp_nx = nos; nos_nx = tos; state_nx = ST_ROTW; end
            CMD_REPL: tos_nx = bus.din;
            CMD_BIN:  begin tos_nx = bus.din; state_nx = ST_FILL; end
            default: ;
          endcase
        end
      end
      ST_FILL: begin
        nos_nx   = mio.vo;
        state_nx = ST_IDLE;
      end
      ST_ROTW: begin
        // Popped third cell becomes TOS while old NOS goes back underneath.
        tos_nx   = mio.vo;
        mem_op   = SOP_PUSH;
        mem_en   = 1'b1;
        mem_vi   = tmp;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      tos   <= '0;
      nos   <= '0;
      tmp   <= '0;
      depth <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      state <= state_nx;
      tos   <= tos_nx;
      nos   <= nos_nx;
      tmp   <= tmp_nx;
      depth <= depth_nx;
      ovf   <= ovf_nx;
      udf   <= udf_nx;
    end
  end

  assign mio.op = mem_op;
  assign mio.en = mem_en;
  assign mio.vi = mem_vi;

  assign bus.rdy    = (state == ST_IDLE);
  assign bus.tos    = tos;
  assign bus.nos    = nos;
  assign bus.depth  = depth;
  assign bus.ovf    = ovf;
  assign bus.udf    = udf;
  assign bus.mem_op = mem_op;
  assign bus.mem_en = mem_en;
  assign bus.mem_vi = mem_vi;
  assign bus.mem_vo = mio.vo;

endmodule
`default_nettype wire

// File: tb/tb_stack_ctl.sv
`default_nettype none
// =====================================================================
// tb_stack_ctl : vector table, corner sequences and random model check
// rev 1.0
// =====================================================================
module tb_stack_ctl;
  import forthsuper_pkg::*;

  localparam int DEPTH = 64;
  localparam int DSZ   = 32;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] din;
    logic [31:0] tos;
    logic [31:0] nos;
    logic [31:0] depth;
    logic [31:0] busy;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] mdl[$];
  logic        m_ovf, m_udf;

  always #5 clk = ~clk;

  stack_ctl_if #(.DEPTH(DEPTH), .DSZ(DSZ)) bus ();

  stack_ctl #(.DEPTH(DEPTH), .DSZ(DSZ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    bus.req = 1'b0;
    bus.cmd = 4'd0;
    bus.din = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] d,
                       output logic [1:0] op, output logic en);
    bus.cmd = c;
    bus.din = d;
    bus.req = 1'b1;
    #1;
    op = bus.mem_op;
    en = bus.mem_en;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
  endtask

  task automatic wait_idle(output int busy);
    busy = 0;
    while (!bus.rdy && busy < 8) begin
      @(posedge clk);
      #1;
      busy++;
    end
    if (busy >= 8) begin
      total++;
      bad++;
      $display("FAIL rdy_timeout: got rdy=0 want rdy=1 within 8 cycles");
    end
  endtask

  function automatic int delta_of(input logic [3:0] c);
    case (c)
      CMD_PUSH, CMD_DUP, CMD_OVER: return 1;
      CMD_DROP, CMD_NIP, CMD_BIN:  return -1;
      default:                     return 0;
    endcase
  endfunction

  function automatic int need_of(input logic [3:0] c);
    case (c)
      CMD_DROP, CMD_DUP, CMD_REPL:          return 1;
      CMD_SWAP, CMD_OVER, CMD_NIP, CMD_BIN: return 2;
      CMD_ROT:                              return 3;
      default:                              return 0;
    endcase
  endfunction

  function automatic bit is_legal(input logic [3:0] c);
    int dep;
    dep = mdl.size() - 2;
    return !((delta_of(c) == 1 && dep == DEPTH) || dep < need_of(c));
  endfunction

  task automatic mdl_reset();
    mdl = '{32'd0, 32'd0};
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Logical stack as a list; the two zero cells below model the reset TOS/NOS.
  task automatic mdl_apply(input logic [3:0] c, input logic [31:0] d, output logic touches);
    logic [31:0] a, b, t;
    int dep;
    dep = mdl.size() - 2;
    touches = 1'b0;
`ifdef STK_GUARD_EN
    if (delta_of(c) == 1 && dep == DEPTH) begin m_ovf = 1'b1; return; end
    if (dep < need_of(c)) begin m_udf = 1'b1; return; end
`endif
    touches = (delta_of(c) != 0) || (c == CMD_ROT);
    case (c)
      CMD_PUSH: mdl.push_back(d);
      CMD_DROP: void'(mdl.pop_back());
      CMD_DUP:  mdl.push_back(mdl[$]);
      CMD_SWAP: begin t = mdl.pop_back(); b = mdl.pop_back(); mdl.push_back(t); mdl.push_back(b); end
      CMD_OVER: mdl.push_back(mdl[$-1]);
      CMD_NIP:  begin t = mdl.pop_back(); void'(mdl.pop_back()); mdl.push_back(t); end
      CMD_ROT:  begin
        t = mdl.pop_back(); b = mdl.pop_back(); a = mdl.pop_back();
        mdl.push_back(b); mdl.push_back(t); mdl.push_back(a);
      end
      CMD_REPL: mdl[$] = d;
      CMD_BIN:  begin void'(mdl.pop_back()); void'(mdl.pop_back()); mdl.push_back(d); end
      default: ;
    endcase
  endtask

  initial begin
    vec_t        tbl[18];
    logic [1:0]  op;
    logic        en;
    int          busy;

    tbl[0]  = '{CMD_PUSH, 32'd1,  32'd1,  32'd0, 32'd1, 32'd0};
    tbl[1]  = '{CMD_PUSH, 32'd2,  32'd2,  32'd1, 32'd2, 32'd0};
    tbl[2]  = '{CMD_PUSH, 32'd3,  32'd3,  32'd2, 32'd3, 32'd0};
    tbl[3]  = '{CMD_SWAP, 32'd0,  32'd2,  32'd3, 32'd3, 32'd0};
    tbl[4]  = '{CMD_OVER, 32'd0,  32'd3,  32'd2, 32'd4, 32'd0};
    tbl[5]  = '{CMD_ROT,  32'd0,  32'd3,  32'd3, 32'd4, 32'd1};
    tbl[6]  = '{CMD_DROP, 32'd0,  32'd3,  32'd2, 32'd3, 32'd1};
    tbl[7]  = '{CMD_DROP, 32'd0,  32'd2,  32'd1, 32'd2, 32'd1};
    tbl[8]  = '{CMD_DROP, 32'd0,  32'd1,  32'd0, 32'd1, 32'd1};
    tbl[9]  = '{CMD_DROP, 32'd0,  32'd0,  32'd0, 32'd0, 32'd1};
    tbl[10] = '{CMD_PUSH, 32'd5,  32'd5,  32'd0, 32'd1, 32'd0};
    tbl[11] = '{CMD_PUSH, 32'd7,  32'd7,  32'd5, 32'd2, 32'd0};
    tbl[12] = '{CMD_BIN,  32'd12, 32'd12, 32'd0, 32'd1, 32'd1};
    tbl[13] = '{CMD_REPL, 32'd9,  32'd9,  32'd0, 32'd1, 32'd0};
    tbl[14] = '{CMD_PUSH, 32'd4,  32'd4,  32'd9, 32'd2, 32'd0};
    tbl[15] = '{CMD_NIP,  32'd0,  32'd4,  32'd0, 32'd1, 32'd1};
    tbl[16] = '{CMD_DUP,  32'd0,  32'd4,  32'd4, 32'd2, 32'd0};
    tbl[17] = '{4'd13,    32'd77, 32'd4,  32'd4, 32'd2, 32'd0};

    do_reset();
    #1;
    chk("reset_tos", bus.tos, 32'd0);
    chk("reset_nos", bus.nos, 32'd0);
    chk("reset_depth", 32'(bus.depth), 32'd0);
    chk("reset_rdy", 32'(bus.rdy), 32'd1);
    chk("reset_flags", {30'd0, bus.ovf, bus.udf}, 32'd0);
    chk("reset_memop", 32'(bus.mem_op), 32'(SOP_READ));

    for (int i = 0; i < 18; i++) begin
      issue(tbl[i].cmd, tbl[i].din, op, en);
      wait_idle(busy);
      chk($sformatf("vec%0d_tos", i), bus.tos, tbl[i].tos);
      chk($sformatf("vec%0d_nos", i), bus.nos, tbl[i].nos);
      chk($sformatf("vec%0d_depth", i), 32'(bus.depth), tbl[i].depth);
      chk($sformatf("vec%0d_busy", i), 32'(busy), tbl[i].busy);
    end

    // DROP: POP driven before E0, TOS/depth at E0, NOS at E1
    do_reset();
    issue(CMD_PUSH, 32'd10, op, en);
    issue(CMD_PUSH, 32'd20, op, en);
    issue(CMD_PUSH, 32'd30, op, en);
    issue(CMD_DROP, 32'd0, op, en);
    chk("drop_memop", 32'(op), 32'(SOP_POP));
    chk("drop_memen", 32'(en), 32'd1);
    chk("drop_e0_tos", bus.tos, 32'd20);
    chk("drop_e0_depth", 32'(bus.depth), 32'd2);
    chk("drop_e0_rdy", 32'(bus.rdy), 32'd0);
    @(posedge clk);
    #1;
    chk("drop_e1_nos", bus.nos, 32'd10);
    chk("drop_e1_rdy", 32'(bus.rdy), 32'd1);

    // ROT interrupted by reset in the writeback cycle
    do_reset();
    issue(CMD_PUSH, 32'd1, op, en);
    issue(CMD_PUSH, 32'd2, op, en);
    issue(CMD_PUSH, 32'd3, op, en);
    issue(CMD_ROT, 32'd0, op, en);
    chk("rot_memop", 32'(op), 32'(SOP_POP));
    chk("rot_e0_nos", bus.nos, 32'd3);
    chk("rot_e0_rdy", 32'(bus.rdy), 32'd0);
    chk("rotw_memop", 32'(bus.mem_op), 32'(SOP_PUSH));
    chk("rotw_memvi", bus.mem_vi, 32'd2);
    rst = 1'b0;
    #1;
    chk("rstmid_tos", bus.tos, 32'd0);
    chk("rstmid_nos", bus.nos, 32'd0);
    chk("rstmid_depth", 32'(bus.depth), 32'd0);
    chk("rstmid_rdy", 32'(bus.rdy), 32'd1);
    chk("rstmid_mem", {29'd0, bus.mem_op, bus.mem_en}, {29'd0, SOP_READ, 1'b0});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    issue(CMD_PUSH, 32'd4, op, en);
    chk("rstmid_push_tos", bus.tos, 32'd4);
    chk("rstmid_push_depth", 32'(bus.depth), 32'd1);

`ifdef STK_GUARD_EN
    do_reset();
    for (int i = 0; i < DEPTH; i++) issue(CMD_PUSH, 32'(i + 1), op, en);
    issue(CMD_PUSH, 32'hDEAD, op, en);
    chk("ovf_memen", 32'(en), 32'd0);
    chk("ovf_flag", 32'(bus.ovf), 32'd1);
    chk("ovf_depth", 32'(bus.depth), 32'(DEPTH));
    chk("ovf_tos", bus.tos, 32'(DEPTH));
    do_reset();
    issue(CMD_PUSH, 32'd1, op, en);
    issue(CMD_NIP, 32'd0, op, en);
    chk("udf_nip_memen", 32'(en), 32'd0);
    chk("udf_nip_flag", 32'(bus.udf), 32'd1);
    chk("udf_nip_rdy", 32'(bus.rdy), 32'd1);
    chk("udf_nip_depth", 32'(bus.depth), 32'd1);
    issue(CMD_PUSH, 32'd2, op, en);
    issue(CMD_ROT, 32'd0, op, en);
    chk("udf_rot_memen", 32'(en), 32'd0);
    chk("udf_rot_rdy", 32'(bus.rdy), 32'd1);
    chk("udf_rot_stack", {bus.tos[15:0], bus.nos[15:0]}, {16'd2, 16'd1});
    chk("udf_rot_depth", 32'(bus.depth), 32'd2);
`else
    do_reset();
    for (int i = 0; i < 2 * DEPTH; i++) issue(CMD_PUSH, 32'(i + 1), op, en);
    chk("wrap_depth", 32'(bus.depth), 32'd0);
    chk("wrap_tos", bus.tos, 32'(2 * DEPTH));
    chk("wrap_flags", {30'd0, bus.ovf, bus.udf}, 32'd0);
`endif

    // Random commands against the list model
    do_reset();
    mdl_reset();
    for (int n = 0; n < 600; n++) begin
      logic [3:0]  c;
      logic [31:0] d;
      logic        touches;
      int          exp_busy;
      c = 4'($urandom_range(0, 15));
`ifndef STK_GUARD_EN
      while (!is_legal(c)) c = 4'($urandom_range(0, 15));
`endif
      d = $urandom;
      mdl_apply(c, d, touches);
      exp_busy = (touches && (delta_of(c) < 0 || c == CMD_ROT)) ? 1 : 0;
      issue(c, d, op, en);
      wait_idle(busy);
      chk("rnd_memen", 32'(en), 32'(touches));
      chk("rnd_busy", 32'(busy), 32'(exp_busy));
      chk("rnd_tos", bus.tos, mdl[$]);
      chk("rnd_nos", bus.nos, mdl[$-1]);
      chk("rnd_depth", 32'(bus.depth), 32'(mdl.size() - 2));
      chk("rnd_flags", {30'd0, bus.ovf, bus.udf}, {30'd0, m_ovf, m_udf});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
